// File: rtl/pc_seq_pkg.sv
// Shared types for the program-flow sequencer: flow-op encoding, FSM states
// and the default address width.
package pc_seq_pkg;

    localparam int PC_W_DEFAULT = 20;

    typedef enum logic [2:0] {
        OP_ADV   = 3'd0,
        OP_JMP   = 3'd1,
        OP_JMPZ  = 3'd2,
        OP_JMPNZ = 3'd3,
        OP_CALL  = 3'd4,
        OP_RET   = 3'd5,
        OP_HALT  = 3'd6,
        OP_RSVD  = 3'd7
    } op_code_t;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; dout always shows the most recently pushed entry.
// The caller guarantees push and pop are never asserted together.
module ret_stack #(
    parameter int PC_W        = 20,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(STACK_DEPTH);

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [AW:0]     count;
    logic [AW-1:0]   top_idx;

    // When full the low count bits wrap to zero, so top_idx still lands on the last slot.
    assign top_idx = count[AW-1:0] - AW'(1);
    assign dout    = mem[top_idx];
    assign full    = (count == (AW+1)'(STACK_DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[count[AW-1:0]] <= din;
            count              <= count + (AW+1)'(1);
        end else if (pop) begin
            count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-flow sequencer: owns the PC, runs the fetch/exec handshake and
// executes JMP/JMPZ/JMPNZ/CALL/RET/HALT with a return-address stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W         = PC_W_DEFAULT,
    parameter int              STACK_DEPTH  = 8,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            fetch_req,
    output logic [PC_W-1:0] fetch_addr,
    input  logic            fetch_ack,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_code,
    input  logic            zero_flag,
    input  logic [PC_W-1:0] jmp_address,
    output logic [PC_W-1:0] pc,
    output logic            stack_err,
    output logic            halted
);

    state_t          state;
    state_t          next_state;
    op_code_t        op;
    logic            accept;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] next_pc;
    logic            push;
    logic            pop;
    logic            err_set;
    logic [PC_W-1:0] stack_top;
    logic            stack_full;
    logic            stack_empty;

    assign op         = op_code_t'(op_code);
    assign accept     = (state == ST_EXEC) && op_valid;
    assign pc_inc     = pc + PC_W'(1);
    assign fetch_addr = pc;

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stack_top),
        .full  (stack_full),
        .empty (stack_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_BOOT;
            pc        <= RESET_VECTOR;
            stack_err <= 1'b0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            if (err_set) begin
                stack_err <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_BOOT:  next_state = ST_FETCH;
            ST_FETCH: if (fetch_ack) next_state = ST_EXEC;
            ST_EXEC:  if (op_valid) next_state = (op == OP_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:  next_state = ST_HALT;
        endcase
    end

    // Stack overflow/underflow degrades the op to a plain advance.
    always_comb begin
        next_pc = pc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (accept) begin
            unique case (op)
                OP_ADV, OP_RSVD: next_pc = pc_inc;
                OP_JMP:          next_pc = jmp_address;
                OP_JMPZ:         next_pc = zero_flag ? jmp_address : pc_inc;
                OP_JMPNZ:        next_pc = zero_flag ? pc_inc : jmp_address;
                OP_CALL: begin
                    if (stack_full) begin
                        err_set = 1'b1;
                        next_pc = pc_inc;
                    end else begin
                        push    = 1'b1;
                        next_pc = jmp_address;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        err_set = 1'b1;
                        next_pc = pc_inc;
                    end else begin
                        pop     = 1'b1;
                        next_pc = stack_top;
                    end
                end
                OP_HALT:         next_pc = pc;
            endcase
        end
    end

    always_comb begin
        fetch_req = (state == ST_FETCH);
        op_ready  = (state == ST_EXEC);
        halted    = (state == ST_HALT);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed flow-control cases plus a
// randomized instruction stream checked against a transaction-level model.
module tb_pc_sequencer;

    localparam int PC_W  = 20;
    localparam int DEPTH = 8;

    localparam logic [2:0] C_ADV   = 3'd0;
    localparam logic [2:0] C_JMP   = 3'd1;
    localparam logic [2:0] C_JMPZ  = 3'd2;
    localparam logic [2:0] C_JMPNZ = 3'd3;
    localparam logic [2:0] C_CALL  = 3'd4;
    localparam logic [2:0] C_RET   = 3'd5;
    localparam logic [2:0] C_HALT  = 3'd6;
    localparam logic [2:0] C_RSVD  = 3'd7;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            fetch_req;
    logic [PC_W-1:0] fetch_addr;
    logic            fetch_ack = 1'b0;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [2:0]      op_code = 3'd0;
    logic            zero_flag = 1'b0;
    logic [PC_W-1:0] jmp_address = '0;
    logic [PC_W-1:0] pc;
    logic            stack_err;
    logic            halted;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_stack [$];
    logic            m_err;
    logic            m_halted;

    pc_sequencer #(
        .PC_W         (PC_W),
        .STACK_DEPTH  (DEPTH),
        .RESET_VECTOR ('0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .zero_flag   (zero_flag),
        .jmp_address (jmp_address),
        .pc          (pc),
        .stack_err   (stack_err),
        .halted      (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_pc     = '0;
        m_stack.delete();
        m_err    = 1'b0;
        m_halted = 1'b0;
    endtask

    // Transaction-level reference: next PC, stack contents and error flag.
    task automatic modelExec(input logic [2:0] op, input logic zf, input logic [PC_W-1:0] addr);
        logic [PC_W-1:0] nxt;
        nxt = m_pc + 20'd1;
        case (op)
            C_JMP:   m_pc = addr;
            C_JMPZ:  m_pc = zf ? addr : nxt;
            C_JMPNZ: m_pc = zf ? nxt : addr;
            C_CALL: begin
                if (m_stack.size() == DEPTH) begin
                    m_err = 1'b1;
                    m_pc  = nxt;
                end else begin
                    m_stack.push_back(nxt);
                    m_pc = addr;
                end
            end
            C_RET: begin
                if (m_stack.size() == 0) begin
                    m_err = 1'b1;
                    m_pc  = nxt;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end
            C_HALT:  m_halted = 1'b1;
            default: m_pc = nxt;
        endcase
    endtask

    task automatic waitFetch(output int waited);
        waited = 0;
        while (!fetch_req && waited < 50) begin
            step();
            waited++;
        end
        checkOutput("fetch_req_wait", {31'd0, fetch_req}, 32'd1);
    endtask

    task automatic resetDut();
        fetch_ack = 1'b0;
        op_valid  = 1'b0;
        rst       = 1'b1;
        step();
        step();
        modelReset();
        checkOutput("rst_pc", {12'd0, pc}, 32'd0);
        checkOutput("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
        checkOutput("rst_op_ready", {31'd0, op_ready}, 32'd0);
        checkOutput("rst_stack_err", {31'd0, stack_err}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
    endtask

    // One full instruction: fetch handshake with ackDly wait cycles, then op accept.
    task automatic applyStimulus(input logic [2:0] op, input logic zf, input logic [PC_W-1:0] addr,
                                 input int ackDly, input int vldDly);
        int w;
        waitFetch(w);
        checkOutput("fetch_addr", {12'd0, fetch_addr}, {12'd0, m_pc});
        for (int i = 0; i < ackDly; i++) begin
            step();
            checkOutput("fetch_hold_req", {31'd0, fetch_req}, 32'd1);
            checkOutput("fetch_hold_addr", {12'd0, fetch_addr}, {12'd0, m_pc});
        end
        fetch_ack = 1'b1;
        step();
        fetch_ack = 1'b0;
        checkOutput("op_ready", {31'd0, op_ready}, 32'd1);
        for (int i = 0; i < vldDly; i++) begin
            step();
            checkOutput("op_ready_hold", {31'd0, op_ready}, 32'd1);
        end
        op_valid    = 1'b1;
        op_code     = op;
        zero_flag   = zf;
        jmp_address = addr;
        step();
        op_valid    = 1'b0;
        zero_flag   = $urandom_range(0, 1) == 1;
        jmp_address = PC_W'($urandom);
        modelExec(op, zf, addr);
        checkOutput("pc", {12'd0, pc}, {12'd0, m_pc});
        checkOutput("stack_err", {31'd0, stack_err}, {31'd0, m_err});
        checkOutput("halted", {31'd0, halted}, {31'd0, m_halted});
    endtask

    initial begin
        int w;
        int c0;
        logic [2:0] rop;

        resetDut();

        // Back-to-back ADV stream: one new fetch address every 2 cycles.
        waitFetch(w);
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(C_ADV, 1'b0, '0, 0, 0);
        end
        waitFetch(w);
        checkOutput("adv_throughput", cyc - c0, 32'd8);
        checkOutput("adv_addr4", {12'd0, fetch_addr}, 32'd4);

        // Conditional jumps, both polarities.
        applyStimulus(C_JMPZ, 1'b1, 20'h00400, 0, 0);
        applyStimulus(C_JMPZ, 1'b0, 20'h00800, 0, 0);
        applyStimulus(C_JMPNZ, 1'b0, 20'h00400, 0, 0);
        applyStimulus(C_JMPNZ, 1'b1, 20'h00800, 0, 0);
        checkOutput("jmpnz_fallthru", {12'd0, pc}, 32'h00401);

        // CALL / ADV / RET.
        applyStimulus(C_JMP, 1'b0, 20'h00010, 0, 0);
        applyStimulus(C_CALL, 1'b0, 20'h00100, 0, 0);
        applyStimulus(C_ADV, 1'b0, '0, 0, 0);
        applyStimulus(C_RET, 1'b0, '0, 0, 0);
        checkOutput("ret_addr", {12'd0, pc}, 32'h00011);

        // Nine nested CALLs then nine RETs: overflow then underflow.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(C_CALL, 1'b0, PC_W'(20'h01000 + i * 20'h100), 0, 0);
        end
        checkOutput("overflow_err", {31'd0, stack_err}, 32'd1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(C_RET, 1'b0, '0, 0, 0);
        end
        checkOutput("underflow_err", {31'd0, stack_err}, 32'd1);

        // PC wrap, including a wrapped return address.
        resetDut();
        applyStimulus(C_JMP, 1'b0, 20'hFFFFF, 0, 0);
        applyStimulus(C_RSVD, 1'b0, '0, 0, 0);
        checkOutput("wrap_adv", {12'd0, pc}, 32'd0);
        applyStimulus(C_JMP, 1'b0, 20'hFFFFF, 0, 0);
        applyStimulus(C_CALL, 1'b0, 20'h00055, 0, 0);
        applyStimulus(C_RET, 1'b0, '0, 0, 0);
        checkOutput("wrap_ret", {12'd0, pc}, 32'd0);

        // Stalled fetch, then reset in the middle of another stalled fetch.
        applyStimulus(C_JMP, 1'b0, 20'h00234, 5, 2);
        waitFetch(w);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_req", {31'd0, fetch_req}, 32'd0);
        checkOutput("rst_async_pc", {12'd0, pc}, 32'd0);
        resetDut();

        // Randomized stream with random handshake delays.
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == C_HALT) rop = C_CALL;
            applyStimulus(rop, $urandom_range(0, 1) == 1, PC_W'($urandom),
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // HALT is terminal until reset.
        applyStimulus(C_HALT, 1'b0, '0, 1, 1);
        fetch_ack = 1'b1;
        op_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checkOutput("halt_req", {31'd0, fetch_req}, 32'd0);
            checkOutput("halt_flag", {31'd0, halted}, 32'd1);
        end
        checkOutput("halt_pc", {12'd0, pc}, {12'd0, m_pc});
        resetDut();
        applyStimulus(C_ADV, 1'b0, '0, 0, 0);
        checkOutput("recover_pc", {12'd0, pc}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
